// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div unit: divider FSM states and RISC-V M-extension func3 codes.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam logic [2:0] R_INST_FUNC3_DIV  = 3'b100;
  localparam logic [2:0] R_INST_FUNC3_DIVU = 3'b101;
  localparam logic [2:0] R_INST_FUNC3_REM  = 3'b110;
  localparam logic [2:0] R_INST_FUNC3_REMU = 3'b111;

  function automatic logic is_signed_op(input logic [2:0] func3);
    return (func3 == R_INST_FUNC3_DIV) || (func3 == R_INST_FUNC3_REM);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Drops into the divider slot of the mul/div wrapper.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_stall,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        op_ready,
  output logic [31:0] op_out
);

  div_state_t  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        sel_rem_q;
  logic        quo_neg_q;
  logic        rem_neg_q;

  logic        in_signed;
  logic [31:0] mag1, mag2;
  logic        div_zero, overflow;
  logic [32:0] shifted, diff;
  logic [31:0] step_rem, step_quo;
  logic [31:0] fin_quo, fin_rem;

  always_comb begin
    in_signed = is_signed_op(op);
    mag1      = (in_signed && op1[31]) ? -op1 : op1;
    mag2      = (in_signed && op2[31]) ? -op2 : op2;
    div_zero  = (op2 == 32'd0);
    overflow  = in_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
  end

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    step_quo = {quo_q[30:0], ~diff[32]};
    fin_quo  = quo_neg_q ? -step_quo : step_quo;
    fin_rem  = rem_neg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (op_valid) state_d = (div_zero || overflow) ? DONE : CALC;
      CALC: begin
        if (!op_valid)            state_d = IDLE;
        else if (cnt_q == 6'd31)  state_d = DONE;
      end
      DONE: if (!op_valid || !op_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sel_rem_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      op_ready  <= 1'b0;
      op_out    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            cnt_q     <= '0;
            sel_rem_q <= op[1];
            quo_neg_q <= in_signed && (op1[31] ^ op2[31]);
            rem_neg_q <= in_signed && op1[31];
            // Fast paths bypass sign correction: results are architecturally fixed.
            if (div_zero) begin
              op_ready <= 1'b1;
              op_out   <= op[1] ? op1 : 32'hFFFF_FFFF;
            end else if (overflow) begin
              op_ready <= 1'b1;
              op_out   <= op[1] ? 32'd0 : 32'h8000_0000;
            end else begin
              quo_q <= mag1;
              rem_q <= '0;
              dvs_q <= mag2;
            end
          end
        end
        CALC: begin
          if (op_valid) begin
            cnt_q <= cnt_q + 6'd1;
            quo_q <= step_quo;
            rem_q <= step_rem;
            if (cnt_q == 6'd31) begin
              op_ready <= 1'b1;
              op_out   <= sel_rem_q ? fin_rem : fin_quo;
            end
          end
        end
        DONE: begin
          if (state_d == IDLE) begin
            op_ready <= 1'b0;
            op_out   <= '0;
          end
        end
        default: begin
          op_ready <= 1'b0;
          op_out   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results, fast paths,
// stall, flush and asynchronous reset behaviour.
module tb_div_iter;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_stall;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        op_ready;
  logic [31:0] op_out;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8] = '{
    '{F_DIVU, 32'h8000_0000, 32'd1,          32'h8000_0000},
    '{F_REMU, 32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F},
    '{F_DIV,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD},
    '{F_REM,  32'd7,         32'hFFFF_FFFE,  32'h0000_0001},
    '{F_DIV,  32'h8000_0000, 32'd3,          32'hD555_5556},
    '{F_REM,  32'h8000_0000, 32'd3,          32'hFFFF_FFFE},
    '{F_DIVU, 32'd1,         32'hFFFF_FFFF,  32'h0000_0000},
    '{F_REMU, 32'd1,         32'hFFFF_FFFF,  32'h0000_0001}
  };

  always #5 clk = ~clk;

  div_iter dut (
    .clk      (clk),
    .rstn     (rstn),
    .op_stall (op_stall),
    .op_valid (op_valid),
    .op       (op),
    .op1      (op1),
    .op2      (op2),
    .op_ready (op_ready),
    .op_out   (op_out)
  );

  // Issues one request and counts edges from the accept edge until op_ready is seen (-1 on timeout).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int lat, output logic [31:0] res);
    @(negedge clk);
    op       = f;
    op1      = a;
    op2      = b;
    op_valid = 1'b1;
    lat      = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (op_ready) break;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        op  = 3'($urandom_range(4, 7));
      end
    end
    if (!op_ready) lat = -1;
    res = op_out;
  endtask

  task automatic consume();
    op_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    op_stall = 1'b0;
    op_valid = 1'b0;
    op       = 3'b000;
    op1      = '0;
    op2      = '0;
    #12;
    tests_run++;
    if (op_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 0", op_ready);
    end
    tests_run++;
    if (op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got %h expected 00000000", op_out);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] res;
    run_op(F_DIV, 32'd100, 32'd7, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("[TB] FAIL div_latency: got %0d expected 33", lat);
    end
    tests_run++;
    if (res !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL div_100_7: got %h expected 0000000e", res);
    end
    consume();
    tests_run++;
    if (op_ready !== 1'b0 || op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL bubble_after_done: got ready=%b out=%h expected ready=0 out=00000000",
               op_ready, op_out);
    end
    run_op(F_REM, 32'd100, 32'd7, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL rem_100_7: got lat=%0d res=%h expected lat=33 res=00000002", lat, res);
    end
    consume();
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] res;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("[TB] FAIL div_m7_2: got lat=%0d res=%h expected lat=33 res=fffffffd", lat, res);
    end
    consume();
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, res);
    tests_run++;
    if (res !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL rem_m7_2: got %h expected ffffffff", res);
    end
    consume();
    run_op(F_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, res);
    tests_run++;
    if (res !== 32'h7FFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL divu_fff9_2: got %h expected 7ffffffc", res);
    end
    consume();
  endtask

  task automatic test_fast_path();
    int lat;
    logic [31:0] res;
    run_op(F_DIVU, 32'd5, 32'd0, 1'b0, lat, res);
    tests_run++;
    if (lat !== 1 || res !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL divu_5_0: got lat=%0d res=%h expected lat=1 res=ffffffff", lat, res);
    end
    consume();
    run_op(F_REMU, 32'd5, 32'd0, 1'b0, lat, res);
    tests_run++;
    if (lat !== 1 || res !== 32'd5) begin
      tests_failed++;
      $display("[TB] FAIL remu_5_0: got lat=%0d res=%h expected lat=1 res=00000005", lat, res);
    end
    consume();
    run_op(F_REM, 32'hFFFF_FFF9, 32'd0, 1'b0, lat, res);
    tests_run++;
    if (lat !== 1 || res !== 32'hFFFF_FFF9) begin
      tests_failed++;
      $display("[TB] FAIL rem_m7_0: got lat=%0d res=%h expected lat=1 res=fffffff9", lat, res);
    end
    consume();
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
    tests_run++;
    if (lat !== 1 || res !== 32'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL div_overflow: got lat=%0d res=%h expected lat=1 res=80000000", lat, res);
    end
    consume();
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
    tests_run++;
    if (lat !== 1 || res !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rem_overflow: got lat=%0d res=%h expected lat=1 res=00000000", lat, res);
    end
    consume();
  endtask

  task automatic test_operand_hold();
    int lat;
    logic [31:0] res;
    run_op(F_DIVU, 32'd100, 32'd7, 1'b1, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL operand_hold: got lat=%0d res=%h expected lat=33 res=0000000e", lat, res);
    end
    consume();
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] res;
    op_stall = 1'b1;
    run_op(F_DIV, 32'd100, 32'd7, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL stall_first: got lat=%0d res=%h expected lat=33 res=0000000e", lat, res);
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (op_ready !== 1'b1 || op_out !== 32'd14) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold: got ready=%b out=%h expected ready=1 out=0000000e",
                 op_ready, op_out);
      end
    end
    consume();
    tests_run++;
    if (op_ready !== 1'b0 || op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got ready=%b out=%h expected ready=0 out=00000000",
               op_ready, op_out);
    end
    // A withdrawn request leaves DONE even while the consumer is still stalling.
    op_stall = 1'b1;
    run_op(F_DIVU, 32'd9, 32'd3, 1'b0, lat, res);
    tests_run++;
    if (res !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL stall_divu_9_3: got %h expected 00000003", res);
    end
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b0 || op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL done_flush: got ready=%b out=%h expected ready=0 out=00000000",
               op_ready, op_out);
    end
    op_stall = 1'b0;
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    logic [31:0] res;
    @(negedge clk);
    op       = F_DIV;
    op1      = 32'd100;
    op2      = 32'd7;
    op_valid = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (op_ready) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL flush_no_result: got %0d ready cycles expected 0", seen);
    end
    run_op(F_DIVU, 32'd9, 32'd3, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL after_flush: got lat=%0d res=%h expected lat=33 res=00000003", lat, res);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    logic [31:0] res;
    op_stall = 1'b1;
    run_op(F_DIV, 32'd100, 32'd7, 1'b0, lat, res);
    rstn = 1'b0;
    #1;
    tests_run++;
    if (op_ready !== 1'b0 || op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_done: got ready=%b out=%h expected ready=0 out=00000000",
               op_ready, op_out);
    end
    op_valid = 1'b0;
    op_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    op_valid = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    tests_run++;
    if (op_ready !== 1'b0 || op_out !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_calc: got ready=%b out=%h expected ready=0 out=00000000",
               op_ready, op_out);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (op_ready) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_result: got %0d ready cycles expected 0", seen);
    end
    run_op(F_DIVU, 32'd9, 32'd3, 1'b0, lat, res);
    tests_run++;
    if (lat !== 33 || res !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL after_reset: got lat=%0d res=%h expected lat=33 res=00000003", lat, res);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, lat, res);
      tests_run++;
      if (lat !== 33 || res !== vecs[i].exp) begin
        tests_failed++;
        $display("[TB] FAIL b2b_vec%0d: got lat=%0d res=%h expected lat=33 res=%h",
                 i, lat, res, vecs[i].exp);
      end
      consume();
      tests_run++;
      if (op_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_bubble%0d: got ready=%b expected 0", i, op_ready);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_fast_path();
    test_operand_hold();
    test_stall();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 op_stall  input  1  downstream stall; result held while high.
REQ-004 op_valid  input  1  request valid; held high by issuer until result consumed; low = flush.
REQ-005 op  input  3  func3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op1  input  32  dividend.
REQ-007 op2  input  32  divisor.
REQ-008 op_ready  output  1  result valid, registered.
REQ-009 op_out  output  32  quotient or remainder; 0 when op_ready low.

Function
REQ-010 Three-state FSM, IDLE/CALC/DONE, SHALL govern all operation.
REQ-011 IDLE: op_valid=1 at edge SHALL latch op, op1, op2; later input changes are ignored until return to IDLE.
REQ-012 Signed ops (DIV, REM) SHALL divide magnitudes, recording quotient sign = op1[31]^op2[31] and remainder sign = op1[31].
REQ-013 Divisor zero SHALL take fast path IDLE->DONE: quotient 0xFFFFFFFF, remainder = op1 (unmodified).
REQ-014 DIV/REM with op1=0x80000000, op2=0xFFFFFFFF SHALL take fast path: quotient 0x80000000, remainder 0.
REQ-015 Otherwise IDLE->CALC; a 6-bit counter loaded 0, restoring radix-2 step per cycle on a 33-bit partial remainder, one quotient bit per cycle, MSB first.
REQ-016 CALC SHALL last exactly 32 cycles; counter==31 step -> DONE with sign correction applied on DONE entry.
REQ-017 Latency: accept at edge N; op_ready high from cycle N+33 (normal) or N+1 (fast path).
REQ-018 DONE: op_ready=1, op_out = quotient (op[1]=0) or remainder (op[1]=1).
REQ-019 DONE with op_stall=1 SHALL stay in DONE, op_out stable; op_stall=0 -> IDLE next edge.
REQ-020 op_valid=0 in CALC (flush) SHALL return to IDLE next edge; op_ready never asserted for that request.
REQ-021 op_valid=0 in DONE SHALL return to IDLE regardless of op_stall.
REQ-022 IDLE after DONE SHALL accept a new request on the first edge with op_valid=1 (one bubble cycle min).
REQ-023 op_ready SHALL never be high for two results without an intervening IDLE cycle.

Reset
REQ-024 rstn low SHALL force IDLE, op_ready=0, op_out=0, counter, quotient, remainder, latched operands all 0, asynchronously.
REQ-025 Reset mid-CALC or mid-DONE SHALL discard the operation; no result appears after release.
REQ-026 After rstn release, first accept SHALL occur on first edge with op_valid=1.

Structure
REQ-027 FSM state typedef (IDLE, CALC, DONE) SHALL live in shared package muldiv_pkg; func3 encodings come from the shared macro header R_INST_FUNC3_* constants.
REQ-028 Single flat module, no sub-module; datapath (33-bit subtractor, shift registers) inline.
REQ-029 Port list SHALL match the existing divider slot in the mul/div wrapper so it drops in unchanged.

Verification
REQ-030 DIV 100/7, op_valid held, op_stall=0 -> op_ready at cycle 33, op_out=14; REM same operands -> 2.
REQ-031 DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
REQ-033 DIV 100/7 with op_stall=1 for cycles 33-40 -> op_ready and op_out=14 stable through 40, IDLE at 41.
REQ-034 Drop op_valid at cycle 10 of CALC -> IDLE at 11, op_ready stays 0; new DIVU 9/3 at cycle 12 -> 3 at cycle 45.
REQ-035 Assert rstn=0 at cycle 15 of CALC -> op_ready=0, op_out=0 immediately; no result after release.
